// File: rtl/dpr_arb_pkg.sv
// Shared types and constants for the dpr port arbiter: ownership states,
// response ids, and the read-return latency.
package dpr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_t;

  localparam logic ID0    = 1'b0;
  localparam logic ID1    = 1'b1;
  localparam int   RD_LAT = 2;

endpackage

// File: rtl/dpr_arb_resp_pipe.sv
// Read-response tracker: DEPTH-stage {valid,id} shift register, latency DEPTH,
// no backpressure (one entry per cycle in, one out); sync active-low reset.
module dpr_arb_resp_pipe
  import dpr_arb_pkg::*;
#(
  parameter int DEPTH = RD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  input  logic in_id,
  output logic out_vld,
  output logic out_id
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= in_vld;
      id_q[0]  <= in_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_id  = id_q[DEPTH-1];

endmodule

// File: rtl/dpr_port_arbiter.sv
// Round-robin/lockable share of one dpr port; gnt same-cycle, rvalid RD_LAT cycles after gnt,
// requesters hold until gnt. Define ARB_STATS_EN to add saturating grant counters.
module dpr_port_arbiter
  import dpr_arb_pkg::*;
#(
  parameter int A_WIDTH  = 4,
  parameter int D_WIDTH  = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               wen0,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic [D_WIDTH-1:0] wdata0,
  input  logic               lock0,
  input  logic               req1,
  input  logic               wen1,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic [D_WIDTH-1:0] wdata1,
  input  logic               lock1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [D_WIDTH-1:0] rdata,
  output logic               mem_en,
  output logic               mem_wen,
  output logic [A_WIDTH-1:0] mem_a,
  output logic [D_WIDTH-1:0] mem_d,
  input  logic [D_WIDTH-1:0] mem_q
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        gnt_cnt0,
  output logic [15:0]        gnt_cnt1
`endif
);

  localparam int CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  own_state_t   state;
  logic         last;
  logic [CW-1:0] lock_cnt;

  logic own0_hold, own1_hold, any_gnt, win_lock, win_wen;
  logic [A_WIDTH-1:0] win_addr;
  logic [D_WIDTH-1:0] win_wdata;
  logic pipe_vld, pipe_id;

  // An owner that drops its request loses ownership this cycle, so the
  // fallthrough below is plain round-robin between whoever is requesting.
  always_comb begin
    own0_hold = (state == OWN0) && req0;
    own1_hold = (state == OWN1) && req1;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (own0_hold)           gnt0 = 1'b1;
      else if (own1_hold)      gnt1 = 1'b1;
      else if (req0 && req1) begin
        if (last == ID1)       gnt0 = 1'b1;
        else                   gnt1 = 1'b1;
      end
      else if (req0)           gnt0 = 1'b1;
      else if (req1)           gnt1 = 1'b1;
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    win_lock  = gnt1 ? lock1  : lock0;
    win_wen   = gnt1 ? wen1   : wen0;
    win_addr  = gnt1 ? addr1  : addr0;
    win_wdata = gnt1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= ID1;
      lock_cnt <= '0;
    end else if (any_gnt) begin
      last <= gnt1 ? ID1 : ID0;
      if (own0_hold || own1_hold) begin
        if (win_lock && (lock_cnt < LOCK_LIM)) begin
          lock_cnt <= lock_cnt + CW'(1);
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      end else if (win_lock) begin
        state    <= gnt1 ? OWN1 : OWN0;
        lock_cnt <= CW'(1);
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end else if (state != IDLE) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en  <= 1'b0;
      mem_wen <= 1'b0;
      mem_a   <= '0;
      mem_d   <= '0;
    end else if (any_gnt) begin
      mem_en  <= 1'b1;
      mem_wen <= win_wen;
      mem_a   <= win_addr;
      mem_d   <= win_wdata;
    end else begin
      mem_en  <= 1'b0;
      mem_wen <= 1'b0;
    end
  end

  dpr_arb_resp_pipe #(
    .DEPTH (RD_LAT)
  ) u_resp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (any_gnt && !win_wen),
    .in_id   (gnt1),
    .out_vld (pipe_vld),
    .out_id  (pipe_id)
  );

  assign rvalid0 = pipe_vld && (pipe_id == ID0);
  assign rvalid1 = pipe_vld && (pipe_id == ID1);
  assign rdata   = mem_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && (gnt_cnt0 != 16'hFFFF)) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1 && (gnt_cnt1 != 16'hFFFF)) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpr_port_arbiter.sv
// Directed bench for dpr_port_arbiter with a behavioural RAM and a read-response scoreboard.
module tb_dpr_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, wen0 = 1'b0, lock0 = 1'b0;
  logic req1 = 1'b0, wen1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_wen;
  logic [DW-1:0] rdata, mem_d;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_q = '0;
`ifdef ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rv_seen = 0;
  int rv_before = 0;
  int n_g0 = 0;

  logic [DW-1:0] ram [16];
  logic [DW-1:0] model [16];

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q [$];
  exp_t e;

  dpr_port_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
`ifdef ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) ram[mem_a] <= mem_d;
      else         mem_q <= ram[mem_a];
    end
  end

  // Monitor: every rvalid pops one expected response and checks id, data and cycle.
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      rv_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected actual rvalid0=%0b rvalid1=%0b cyc=%0d required none", rvalid0, rvalid1, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rvalid0 == rvalid1 || rvalid1 != e.id || rdata !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL rresp actual id=%0b/%0b data=%0h cyc=%0d required id=%0b data=%0h cyc=%0d",
                   rvalid0, rvalid1, rdata, cyc, e.id, e.data, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    req0 = r; wen0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    req1 = r; wen1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  // Called at posedge+1 with inputs driven; checks grants, queues expectations, advances one cycle.
  task automatic step(input string nm, input logic eg0, input logic eg1, input bit track);
    #3;
    chk({nm, "_gnt0"}, 32'(gnt0), 32'(eg0));
    chk({nm, "_gnt1"}, 32'(gnt1), 32'(eg1));
    if (track && eg0) begin
      if (wen0) model[addr0] = wdata0;
      else exp_q.push_back('{1'b0, model[addr0], cyc + 2});
    end
    if (track && eg1) begin
      if (wen1) model[addr1] = wdata1;
      else exp_q.push_back('{1'b1, model[addr1], cyc + 2});
    end
    if (eg0) n_g0++;
    @(posedge clk);
    #1;
  endtask

  logic [0:6] lock_pat = 7'b1111101;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]   = {i[3:0], i[3:0]};
      model[i] = {i[3:0], i[3:0]};
    end
    @(posedge clk);
    #1;

    // Reset held with both requesting.
    drv0(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    drv1(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      step("rst", 1'b0, 1'b0, 1'b1);
    end

    // Contention: strict alternation starting with req0.
    rst_n = 1'b1;
    step("cont0", 1'b1, 1'b0, 1'b1);
    step("cont1", 1'b0, 1'b1, 1'b1);
    step("cont2", 1'b1, 1'b0, 1'b1);
    step("cont3", 1'b0, 1'b1, 1'b1);
    drv0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("idle_a", 1'b0, 1'b0, 1'b1);

    // Write then read the same address on consecutive grants.
    drv0(1'b1, 1'b1, 4'd7, 8'hA5, 1'b0);
    step("wr", 1'b1, 1'b0, 1'b1);
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    chk("wr_mem_wen", 32'(mem_wen), 32'd1);
    chk("wr_mem_a", 32'(mem_a), 32'd7);
    chk("wr_mem_d", 32'(mem_d), 32'hA5);
    drv0(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    step("rd", 1'b1, 1'b0, 1'b1);
    chk("rd_mem_wen", 32'(mem_wen), 32'd0);
    drv0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step("idle_b", 1'b0, 1'b0, 1'b1);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_mem_a_hold", 32'(mem_a), 32'd7);
    for (int i = 0; i < 2; i++) step("idle_b", 1'b0, 1'b0, 1'b1);

    // Give req1 the last grant so req0 wins the lock contention.
    drv1(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    step("prime", 1'b0, 1'b1, 1'b1);

    // Lock: acquiring grant + LOCK_MAX held grants, forced release, req1, re-lock.
    drv0(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step("lock", lock_pat[i], !lock_pat[i], 1'b1);

    // Owner drops its request: req1 is granted in the same cycle.
    drv0(1'b0, 1'b0, 4'd3, 8'h00, 1'b1);
    step("drop", 1'b0, 1'b1, 1'b1);
    drv0(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    step("after_drop", 1'b1, 1'b0, 1'b1);
    drv0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("idle_c", 1'b0, 1'b0, 1'b1);
`ifdef ARB_STATS_EN
    chk("gnt_cnt0", 32'(gnt_cnt0), 32'(n_g0));
`endif

    // Reset mid-read: the in-flight read must never return.
    drv0(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    step("mid", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    rv_before = rv_seen;
    drv1(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    step("mid_rst", 1'b0, 1'b0, 1'b1);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
`ifdef ARB_STATS_EN
    chk("mid_rst_gnt_cnt0", 32'(gnt_cnt0), 32'd0);
`endif
    rst_n = 1'b1;
    drv0(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    step("post_rst", 1'b1, 1'b0, 1'b1);
    drv0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step("post_idle", 1'b0, 1'b0, 1'b1);
    chk("mid_rst_no_rvalid", 32'(rv_seen), 32'(rv_before));
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b0, 1'b1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
